// File: rtl/mon_fifo_ctrl.sv
// mon_fifo_ctrl: round-robin write arbiter and credit-based read scheduler for the monitor FIFO.
// Build option MON_FIFO_CTRL_PRIO0_EN gives requester 0 fixed top priority.
module mon_fifo_ctrl #(
  parameter int DataWidth = 27,
  parameter int AddrWidth = 3,
  parameter int NumReq    = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NumReq-1:0]           ReqIn,
  input  logic [NumReq*DataWidth-1:0] ReqData,
  output logic [NumReq-1:0]           Gnt,
  input  logic                        Clear,
  output logic                        FifoWrite,
  output logic [DataWidth-1:0]        FifoInData,
  output logic                        FifoRead,
  output logic                        FifoReset,
  input  logic                        FifoFull,
  input  logic                        FifoEmpty,
  input  logic                        OutReady,
  output logic                        OutValid,
  output logic [AddrWidth:0]          Level
);

  localparam int Depth = 1 << AddrWidth;
  localparam int IdxW  = $clog2(NumReq);
  localparam int LvlW  = AddrWidth + 1;
  localparam logic [LvlW-1:0] DepthL = LvlW'(Depth);

  typedef enum logic [1:0] {
    FLUSH,
    SETTLE,
    RUN
  } state_e;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [NumReq-1:0]     r_gnt;
  logic                  r_wr;
  logic [DataWidth-1:0]  r_data;
  logic                  r_frst;
  logic [LvlW-1:0]       r_level;
  logic [LvlW-1:0]       r_avail;
  logic [IdxW-1:0]       r_last;

  logic                  w_run;
  logic                  w_read;
  logic                  w_grant;
  logic                  w_hit;
  logic                  w_upd_last;
  logic [IdxW-1:0]       w_win;
  logic [NumReq-1:0]     w_rr_req;
  logic                  w_unused;

  assign w_unused = FifoFull;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      FLUSH:   w_state_nxt = SETTLE;
      SETTLE:  w_state_nxt = RUN;
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = FLUSH;
    endcase
    if (Clear) w_state_nxt = FLUSH;
  end

  assign w_run = (r_state == RUN);

  // Avail blocks reads while the registered FifoEmpty is still stale.
  assign w_read  = OutReady & w_run & (r_avail != '0) & ~FifoEmpty;
  assign w_grant = w_run & ~Clear & (|ReqIn) & (r_level < DepthL);

  always_comb begin : p_arb
    logic [IdxW:0] v_s;
    w_rr_req   = ReqIn;
    w_win      = '0;
    w_hit      = 1'b0;
    w_upd_last = 1'b1;
    v_s        = '0;
`ifdef MON_FIFO_CTRL_PRIO0_EN
    w_rr_req[0] = 1'b0;
`endif
    for (int k = 1; k <= NumReq; k++) begin
      v_s = {1'b0, r_last} + (IdxW+1)'(k);
      if (v_s >= (IdxW+1)'(NumReq))
        v_s = v_s - (IdxW+1)'(NumReq);
      if (!w_hit && w_rr_req[v_s[IdxW-1:0]]) begin
        w_hit = 1'b1;
        w_win = v_s[IdxW-1:0];
      end
    end
`ifdef MON_FIFO_CTRL_PRIO0_EN
    if (ReqIn[0]) begin
      w_win      = '0;
      w_upd_last = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= FLUSH;
      r_frst  <= 1'b1;
      r_gnt   <= '0;
      r_wr    <= 1'b0;
      r_data  <= '0;
      r_level <= '0;
      r_avail <= '0;
      r_last  <= IdxW'(NumReq - 1);
    end else begin
      r_state <= w_state_nxt;
      r_frst  <= (r_state == FLUSH) | Clear;
      r_gnt   <= w_grant ? (NumReq'(1) << w_win) : '0;
      r_wr    <= w_grant;
      if (w_grant)
        r_data <= ReqData[w_win*DataWidth +: DataWidth];
      if (w_grant && w_upd_last)
        r_last <= w_win;
      if (Clear) begin
        r_level <= '0;
        r_avail <= '0;
      end else begin
        r_level <= r_level + LvlW'(w_grant) - LvlW'(w_read);
        r_avail <= r_avail + LvlW'(r_wr) - LvlW'(w_read);
      end
    end
  end

  assign Gnt        = r_gnt;
  assign FifoWrite  = r_wr;
  assign FifoInData = r_data;
  assign FifoRead   = w_read;
  assign OutValid   = w_read;
  assign FifoReset  = r_frst;
  assign Level      = r_level;

endmodule

// File: tb/tb_mon_fifo_ctrl.sv
// tb_mon_fifo_ctrl: bench for mon_fifo_ctrl with a lagging-flag FIFO model
// and a write/read data scoreboard.
module tb_mon_fifo_ctrl;

  localparam int DW = 27;
  localparam int AW = 3;
  localparam int NR = 4;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [NR-1:0]    ReqIn;
  logic [NR*DW-1:0] ReqData;
  logic [NR-1:0]    Gnt;
  logic             Clear;
  logic             FifoWrite;
  logic [DW-1:0]    FifoInData;
  logic             FifoRead;
  logic             FifoReset;
  logic             FifoFull;
  logic             FifoEmpty;
  logic             OutReady;
  logic             OutValid;
  logic [AW:0]      Level;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mon_fifo_ctrl #(
    .DataWidth(DW),
    .AddrWidth(AW),
    .NumReq(NR)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ReqIn(ReqIn),
    .ReqData(ReqData),
    .Gnt(Gnt),
    .Clear(Clear),
    .FifoWrite(FifoWrite),
    .FifoInData(FifoInData),
    .FifoRead(FifoRead),
    .FifoReset(FifoReset),
    .FifoFull(FifoFull),
    .FifoEmpty(FifoEmpty),
    .OutReady(OutReady),
    .OutValid(OutValid),
    .Level(Level)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO model: flags are registered from the previous occupancy
  logic [DW-1:0] m_mem [DEPTH];
  logic [AW-1:0] m_wp;
  logic [AW-1:0] m_rp;
  int            m_cnt;
  logic          m_empty;
  logic          m_full;
  int            m_bad = 0;
  logic [DW-1:0] fifo_out;

  assign FifoEmpty = m_empty;
  assign FifoFull  = m_full;
  assign fifo_out  = m_mem[m_rp];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n || FifoReset) begin
      m_wp <= '0;
      m_rp <= '0;
      m_cnt <= 0;
      m_empty <= 1'b1;
      m_full <= 1'b0;
    end else begin
      m_empty <= (m_cnt == 0);
      m_full  <= (m_cnt == DEPTH);
      if (FifoWrite) begin
        if (m_cnt == DEPTH) m_bad <= m_bad + 1;
        m_mem[m_wp] <= FifoInData;
        m_wp <= m_wp + 1'b1;
      end
      if (FifoRead) begin
        if (m_cnt == 0) m_bad <= m_bad + 1;
        m_rp <= m_rp + 1'b1;
      end
      m_cnt <= m_cnt + (FifoWrite ? 1 : 0) - (FifoRead ? 1 : 0);
    end
  end

  // Requesters: each presents {id, seq} and advances seq once granted
  logic [NR-1:0] req_en;
  logic          special;
  int            seq [NR];

  function automatic logic [DW-1:0] word(input int i);
    if (special && i == 2) return 27'h5A5A5A5;
    return {3'(i), 24'(seq[i])};
  endfunction

  assign ReqIn = req_en;

  always_comb begin
    ReqData = '0;
    for (int i = 0; i < NR; i++)
      ReqData[i*DW +: DW] = word(i);
  end

  logic [DW-1:0] sbq [$];

  always @(negedge clk) begin
    if (!reset_n || FifoReset) begin
      sbq.delete();
    end else begin
      chk("rd_eq_valid", 32'(OutValid), 32'(FifoRead));
      chk("wr_eq_gnt", 32'(FifoWrite), 32'(|Gnt));
      if (OutValid) begin
        chk("sb_nonempty", 32'(sbq.size() > 0), 32'(1));
        if (sbq.size() > 0)
          chk("rd_data", 32'(fifo_out), 32'(sbq.pop_front()));
      end
      if (Gnt != '0) begin
        chk("gnt_onehot", 32'($onehot(Gnt)), 32'(1));
        for (int i = 0; i < NR; i++) begin
          if (Gnt[i]) begin
            chk("wr_data", 32'(FifoInData), 32'(word(i)));
            sbq.push_back(word(i));
            seq[i]++;
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_gnt", 32'(Gnt), 32'(0));
    chk("rst_wr", 32'(FifoWrite), 32'(0));
    chk("rst_data", 32'(FifoInData), 32'(0));
    chk("rst_frst", 32'(FifoReset), 32'(1));
    chk("rst_level", 32'(Level), 32'(0));
    chk("rst_read", 32'(FifoRead), 32'(0));
    chk("rst_valid", 32'(OutValid), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [19:0] gseq;
  } vec_t;

  vec_t vt [6];

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int got;
    int ng;
    int first;
    logic found;

`ifdef MON_FIFO_CTRL_PRIO0_EN
    vt[0] = '{4'b1111, 20'h11111};
    vt[1] = '{4'b0101, 20'h11111};
    vt[5] = '{4'b0011, 20'h11111};
`else
    vt[0] = '{4'b1111, 20'h18421};
    vt[1] = '{4'b0101, 20'h14141};
    vt[5] = '{4'b0011, 20'h12121};
`endif
    vt[2] = '{4'b1010, 20'h28282};
    vt[3] = '{4'b1000, 20'h88888};
    vt[4] = '{4'b0110, 20'h24242};

    reset_n  = 1'b1;
    Clear    = 1'b0;
    OutReady = 1'b0;
    req_en   = '0;
    special  = 1'b0;

    // Arbitration order and back-to-back throughput from reset
    for (int r = 0; r < 6; r++) begin
      req_en   = vt[r].req;
      OutReady = 1'b1;
      do_reset();
      got = 0;
      for (int k = 1; k <= 20 && got < 5; k++) begin
        cyc();
        if (r == 0 && k == 1) chk("frst_cyc1", 32'(FifoReset), 32'(1));
        if (r == 0 && k == 2) chk("frst_cyc2", 32'(FifoReset), 32'(0));
        if (Gnt != '0) begin
          chk($sformatf("v%0d_gnt%0d", r, got), 32'(Gnt),
              32'(vt[r].gseq[got*4 +: 4]));
          chk($sformatf("v%0d_cyc%0d", r, got), k, 3 + got);
          got++;
        end
      end
      chk($sformatf("v%0d_count", r), got, 5);
    end
    req_en = '0;

`ifdef MON_FIFO_CTRL_PRIO0_EN
    req_en   = 4'b0011;
    OutReady = 1'b1;
    do_reset();
    got = 0;
    for (int k = 1; k <= 12 && got < 4; k++) begin
      cyc();
      if (Gnt != '0) begin
        chk("p0_gnt", 32'(Gnt), 32'(4'b0001));
        got++;
        if (got == 4) req_en = 4'b0010;
      end
    end
    chk("p0_count", got, 4);
    cyc();
    chk("p0_drop", 32'(Gnt), 32'(4'b0010));
    req_en = '0;
`endif

    // Single word into an empty FIFO: read waits for the lagging flag
    req_en   = '0;
    OutReady = 1'b1;
    do_reset();
    repeat (3) cyc();
    special = 1'b1;
    req_en  = 4'b0100;
    found   = 1'b0;
    for (int k = 1; k <= 5 && !found; k++) begin
      cyc();
      if (Gnt != '0) begin
        found = 1'b1;
        chk("sw_gnt", 32'(Gnt), 32'(4'b0100));
        req_en = '0;
      end
    end
    chk("sw_found", 32'(found), 32'(1));
    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk($sformatf("sw_valid%0d", k), 32'(OutValid), 32'(k == 2));
      if (k == 2) chk("sw_data", 32'(fifo_out), 32'(27'h5A5A5A5));
    end
    special = 1'b0;

    // Clear with five words committed, coinciding with a pending request
    req_en   = 4'b1111;
    OutReady = 1'b0;
    do_reset();
    got = 0;
    for (int k = 1; k <= 20 && got < 5; k++) begin
      cyc();
      if (Gnt != '0) begin
        got++;
        if (got == 5) req_en = '0;
      end
    end
    chk("clr_pre_count", got, 5);
    chk("clr_level5", 32'(Level), 32'(5));
    Clear  = 1'b1;
    req_en = 4'b1110;
    cyc();
    Clear = 1'b0;
    chk("clr_frst", 32'(FifoReset), 32'(1));
    chk("clr_level0", 32'(Level), 32'(0));
    chk("clr_gnt1", 32'(Gnt), 32'(0));
    cyc();
    chk("clr_gnt2", 32'(Gnt), 32'(0));
    found = 1'b0;
    for (int k = 1; k <= 6 && !found; k++) begin
      cyc();
      if (Gnt != '0) begin
        found = 1'b1;
        chk("clr_resume", 32'(Gnt), 32'(4'b0010));
      end
    end
    chk("clr_found", 32'(found), 32'(1));
    req_en = '0;

    // Fill to Depth, then one read frees exactly one slot
    req_en   = 4'b1111;
    OutReady = 1'b0;
    do_reset();
    ng = 0;
    for (int k = 1; k <= 24; k++) begin
      cyc();
      if (Gnt != '0) ng++;
    end
    chk("full_grants", ng, 8);
    chk("full_level", 32'(Level), 32'(8));
    chk("full_idle", 32'(Gnt), 32'(0));
    OutReady = 1'b1;
    @(negedge clk);
    chk("full_read", 32'(OutValid), 32'(1));
    cyc();
    OutReady = 1'b0;
    ng = 0;
    first = 0;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      if (Gnt != '0) begin
        ng++;
        if (first == 0) first = k;
      end
    end
    chk("refill_at", first, 1);
    chk("refill_count", ng, 1);
    chk("refill_level", 32'(Level), 32'(8));
    req_en = '0;
    cyc();
    chk("fifo_no_ovf", m_bad, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
